// File: rtl/full_adder6_pkg.sv
// -----------------------------------------------------------------------------
// full_adder6_pkg
// Shared definitions for the registered 6-bit ripple-carry adder.
//   ADDER_WIDTH : default operand/sum width
//   operand_t   : operand vector type at the default width
// -----------------------------------------------------------------------------
package full_adder6_pkg;

    localparam int ADDER_WIDTH = 6;

    typedef logic [ADDER_WIDTH-1:0] operand_t;

endpackage : full_adder6_pkg

// File: rtl/full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// One purely combinational full-adder cell of the ripple chain.
// Ports:
//   a, b  : operand bits
//   cin   : carry into this bit
//   sum   : a ^ b ^ cin
//   cout  : carry out to the next bit
// -----------------------------------------------------------------------------
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum_s;

    assign half_sum_s = a ^ b;
    assign sum        = half_sum_s ^ cin;
    // Generate when both operand bits are set, propagate an incoming carry
    // when exactly one is set.
    assign cout       = (a & b) | (cin & half_sum_s);

endmodule : full_adder_bit

// File: rtl/full_adder6.sv
// -----------------------------------------------------------------------------
// full_adder6
// WIDTH-bit unsigned adder with carry-in/carry-out. A ripple chain of
// full_adder_bit cells feeds a WIDTH+1 bit output register, so results appear
// one CLK edge after the operands are sampled.
// Ports:
//   CLK       : system clock, rising edge
//   RST       : asynchronous active-high reset, clears the outputs
//   X, Y      : unsigned operands
//   Carry_IN  : carry into bit 0
//   BIN_OUT   : registered sum bits
//   Carry_OUT : registered carry out of the top bit (unsigned overflow)
// -----------------------------------------------------------------------------
module full_adder6
    import full_adder6_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Carry_IN,
    output logic [WIDTH-1:0] BIN_OUT,
    output logic             Carry_OUT
);

    logic [WIDTH:0]   c_s;       // c_s[i] is the carry into bit i
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:0]   result_r;  // {carry, sum}

    assign c_s[0] = Carry_IN;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i = i + 1) begin : g_ripple
            full_adder_bit u_bit (
                .a    (X[i]),
                .b    (Y[i]),
                .cin  (c_s[i]),
                .sum  (sum_s[i]),
                .cout (c_s[i+1])
            );
        end
    endgenerate

    // Result register: cleared asynchronously, otherwise captures the chain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result_r <= {(WIDTH+1){1'b0}};
        end else begin
            result_r <= {c_s[WIDTH], sum_s};
        end
    end

    assign BIN_OUT   = result_r[WIDTH-1:0];
    assign Carry_OUT = result_r[WIDTH];

endmodule : full_adder6

// File: tb/tb_full_adder6.sv
// -----------------------------------------------------------------------------
// tb_full_adder6
// Directed, table-driven bench for full_adder6 with hand-computed results.
// -----------------------------------------------------------------------------
module tb_full_adder6;

    logic       CLK;
    logic       RST;
    logic [5:0] X;
    logic [5:0] Y;
    logic       Carry_IN;
    logic [5:0] BIN_OUT;
    logic       Carry_OUT;

    int total;
    int bad;

    typedef struct {
        logic [5:0] x;
        logic [5:0] y;
        logic       cin;
        logic [5:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs [8];

    full_adder6 #(.WIDTH(6)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .X         (X),
        .Y         (Y),
        .Carry_IN  (Carry_IN),
        .BIN_OUT   (BIN_OUT),
        .Carry_OUT (Carry_OUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] exp_sum,
                         input logic exp_cout);
        total = total + 1;
        if (BIN_OUT !== exp_sum || Carry_OUT !== exp_cout) begin
            bad = bad + 1;
            $display("FAIL %s: got sum=%0d cout=%b, expected sum=%0d cout=%b",
                     name, BIN_OUT, Carry_OUT, exp_sum, exp_cout);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{6'd63, 6'd0,  1'b1, 6'd0,  1'b1};
        vecs[1] = '{6'd63, 6'd63, 1'b1, 6'd63, 1'b1};
        vecs[2] = '{6'd31, 6'd1,  1'b0, 6'd32, 1'b0};
        vecs[3] = '{6'd0,  6'd0,  1'b1, 6'd1,  1'b0};
        vecs[4] = '{6'd1,  6'd2,  1'b0, 6'd3,  1'b0};
        vecs[5] = '{6'd10, 6'd5,  1'b0, 6'd15, 1'b0};
        vecs[6] = '{6'd40, 6'd40, 1'b0, 6'd16, 1'b1};
        vecs[7] = '{6'd0,  6'd0,  1'b0, 6'd0,  1'b0};

        // Reset asserted between edges clears outputs immediately and holds.
        RST      = 1'b0;
        X        = 6'd30;
        Y        = 6'd20;
        Carry_IN = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_immediate", 6'd0, 1'b0);
        tick();
        check("rst_held_1", 6'd0, 1'b0);
        tick();
        check("rst_held_2", 6'd0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        check("rst_release", 6'd50, 1'b0);

        // Steady operands keep producing the same result.
        for (int k = 0; k < 6; k++) begin
            tick();
            check("steady", 6'd50, 1'b0);
        end

        // Back-to-back vectors: output holds the previous result until the
        // next edge, then shows the new one.
        for (int i = 0; i < 8; i++) begin
            X        = vecs[i].x;
            Y        = vecs[i].y;
            Carry_IN = vecs[i].cin;
            #1;
            if (i == 0) check("hold_prev", 6'd50, 1'b0);
            else        check("hold_prev", vecs[i-1].exp_sum, vecs[i-1].exp_cout);
            tick();
            check("vector", vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // Mid-stream reset discards the in-flight result; next edge recomputes.
        X        = 6'd40;
        Y        = 6'd40;
        Carry_IN = 1'b0;
        tick();
        check("pre_mid_rst", 6'd16, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("mid_rst_drop", 6'd0, 1'b0);
        #1;
        RST = 1'b0;
        #1;
        check("mid_rst_still0", 6'd0, 1'b0);
        tick();
        check("mid_rst_recover", 6'd16, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_full_adder6

// File: doc/full_adder6.md
Name: full_adder6

Overview:
- 6-bit binary adder with carry-in and carry-out; result registered on the system clock.
- Used as the arithmetic primitive in the datapath; the testbench drives stimulus at clock rate and samples results on later edges.
- Internally a ripple-carry chain of 1-bit full-adder cells feeding an output register.

Parameters:
- WIDTH, 6, operand and sum width in bits. The block is verified only at 6; other values must elaborate cleanly.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  reset; asynchronous, active-high.
- X  input  WIDTH  operand A, unsigned.
- Y  input  WIDTH  operand B, unsigned.
- Carry_IN  input  1  carry into bit 0.
- BIN_OUT  output  WIDTH  registered sum bits [WIDTH-1:0].
- Carry_OUT  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high.
- Arithmetic: {Carry_OUT, BIN_OUT} = X + Y + Carry_IN, computed at WIDTH+1 bits with zero-extended operands.
- Range: the result spans 0 .. 2^(WIDTH+1)-1, i.e. 0..127 at WIDTH=6.
- No signed interpretation and no overflow flag. Carry_OUT is the unsigned overflow indicator.
- Combinational path: bit i cell takes X[i], Y[i] and carry c[i], with c[0] = Carry_IN.
  - sum[i] = X[i] ^ Y[i] ^ c[i]
  - c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]))
  - Carry_OUT source is c[WIDTH].
- Latency: inputs sampled on CLK rising edge N. BIN_OUT and Carry_OUT show the result after edge N and hold until edge N+1.
- Throughput: one new addition per cycle. No handshake, no stall; new inputs may change every cycle.
- Reset value: RST=1 forces BIN_OUT=0 and Carry_OUT=0 immediately, without waiting for a clock edge.
- Outputs stay 0 while RST is held.
- Reset release: the first rising edge with RST=0 captures the current inputs.
- Reset mid-operation: any in-flight result is discarded; there is no recovery of the previous value.
- Boundary cases:
  - All-ones + all-ones + 1 gives sum 2^WIDTH-1 with Carry_OUT=1.
  - All-ones + 0 + 1 wraps the sum to 0 with Carry_OUT=1.
  - 0 + 0 + 0 gives 0.
- X or Z on any input propagates to the registered outputs; no masking.
- No state machine; the only state is the WIDTH+1 bit result register.

Decomposition:
- Shared package full_adder6_pkg:
  - localparam ADDER_WIDTH = 6 as the default for WIDTH.
  - typedef logic [ADDER_WIDTH-1:0] operand_t.
- One sub-module, full_adder_bit: ports a, b, cin, sum, cout; purely combinational.
  - Instantiated WIDTH times in a generate loop to form the ripple chain.
- Top level holds the generate loop, the carry wire vector c[WIDTH:0] and the async-reset output register.

Test Plan:
- Reset: assert RST with inputs X=30, Y=20 -> BIN_OUT=0, Carry_OUT=0 immediately and while held. Release; one edge later BIN_OUT=50 (110010), Carry_OUT=0.
- Steady stimulus: X=30, Y=20, Carry_IN=0 held for 6 cycles -> every cycle after the first reports BIN_OUT=50, Carry_OUT=0.
- Wrap-around: X=63, Y=0, Carry_IN=1 -> BIN_OUT=0, Carry_OUT=1. Then X=63, Y=63, Carry_IN=1 -> BIN_OUT=63, Carry_OUT=1.
- Carry ripple: X=31, Y=1, Carry_IN=0 -> BIN_OUT=32, Carry_OUT=0. Then X=0, Y=0, Carry_IN=1 -> BIN_OUT=1, Carry_OUT=0.
- Back-to-back inputs: X/Y change every cycle through (1,2), (10,5), (40,40) -> outputs 3, 15, 16 with Carry_OUT=1 (80 = 64 + 16). Each result appears exactly one edge after its inputs.
- Mid-stream reset: assert RST asynchronously between edges while X=40, Y=40 -> outputs drop to 0 before the next edge. Release -> the next edge produces BIN_OUT=16, Carry_OUT=1.
